// File: rtl/spi_instruction_receiver.sv
`timescale 1ns/1ps
// Raspberry Pi SPI (mode 0) instruction receiver. The SPI pins are oversampled in
// the clk domain and fixed-length frames are queued for the accelerator core.
module spi_instruction_receiver #(
    parameter int N     = 80,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       RPiclk,
    input  logic                       MOSI,
    input  logic                       cs1,
    output logic [N-1:0]               inst_data,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy,
    output logic                       frame_len_err,
    output logic                       overflow,
    input  logic                       clear_err
);

    // state  | meaning
    // ARM    | wait for the sync chain to refill after reset and cs1 to be high
    // IDLE   | wait for cs1 falling edge
    // SHIFT  | shifting bits on sclk rising edges until cs1 rises
    typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_SHIFT} state_t;

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BIT_W  = $clog2(N + 2);
    localparam int WARM_W = $clog2(SYNC + 2);

    logic [SYNC-1:0]   sclk_sync_q, sclk_sync_d;
    logic [SYNC-1:0]   mosi_sync_q, mosi_sync_d;
    logic [SYNC-1:0]   cs_sync_q, cs_sync_d;
    logic              sclk_hist_q, sclk_hist_d;
    logic              cs_hist_q, cs_hist_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    state_t            state_q, state_d;
    logic [N-1:0]      shift_q, shift_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [N-1:0]      mem_q [DEPTH];
    logic [N-1:0]      mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              len_err_q, len_err_d;
    logic              ovf_q, ovf_d;

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, cs_fall, cs_rise;
    logic push, pop, full, len_set, ovf_set;

    assign sclk_s    = sclk_sync_q[SYNC-1];
    assign mosi_s    = mosi_sync_q[SYNC-1];
    assign cs_s      = cs_sync_q[SYNC-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign cs_fall   = ~cs_s & cs_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;

    assign full = (count_q == CNT_W'(DEPTH));
    assign pop  = inst_valid & inst_ready;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC-2:0], RPiclk};
        mosi_sync_d = {mosi_sync_q[SYNC-2:0], MOSI};
        cs_sync_d   = {cs_sync_q[SYNC-2:0], cs1};
        sclk_hist_d = sclk_s;
        cs_hist_d   = cs_s;
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        warm_d   = warm_q;
        push     = 1'b0;
        len_set  = 1'b0;
        ovf_set  = 1'b0;
        if (warm_q != '0) begin
            warm_d = warm_q - WARM_W'(1);
        end
        case (state_q)
            ST_ARM: begin
                // Reset values of the sync chain are not trusted until it has refilled.
                if (warm_q == '0 && cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    bitcnt_d = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[N-2:0], mosi_s};
                    if (bitcnt_q != BIT_W'(N + 1)) begin
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                    end
                end
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    if (bitcnt_d == BIT_W'(N)) begin
                        if (!full || pop) begin
                            push = 1'b1;
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end else begin
                        len_set = 1'b1;
                    end
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = shift_d;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        len_err_d = len_set | (len_err_q & ~clear_err);
        ovf_d     = ovf_set | (ovf_q & ~clear_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
            warm_q      <= WARM_W'(SYNC + 1);
            state_q     <= ST_ARM;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            len_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_hist_q <= sclk_hist_d;
            cs_hist_q   <= cs_hist_d;
            warm_q      <= warm_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            len_err_q   <= len_err_d;
            ovf_q       <= ovf_d;
        end
    end

    // Frame storage needs no reset; it is only visible while inst_valid is high.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign inst_data     = mem_q[rd_ptr_q];
    assign inst_valid    = (count_q != '0);
    assign fifo_count    = count_q;
    assign busy          = (state_q == ST_SHIFT);
    assign frame_len_err = len_err_q;
    assign overflow      = ovf_q;

endmodule

// File: doc/spi_instruction_receiver.md
Name: spi_instruction_receiver

Overview:
- Next-generation Raspberry Pi SPI instruction receiver.
- Oversamples the RPi SPI pins (RPiclk, MOSI, cs1) in the FPGA system clock domain.
- Assembles fixed-length N-bit instruction frames, validates the frame length, and queues complete frames in a DEPTH-entry FIFO.
- Presents frames to the accelerator core through a valid/ready handshake, with sticky error flags for length errors and overflow.

Parameters:
- N, 80, instruction frame width in bits (MSB received first); N >= 2
- DEPTH, 4, instruction FIFO depth in frames; power of two, >= 2
- SYNC, 2, synchronizer flops per SPI input; >= 2

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- RPiclk  input  1  SPI SCLK from RPi (mode 0), asynchronous; sampled as data
- MOSI  input  1  SPI data from RPi, asynchronous
- cs1  input  1  SPI chip select, active low, asynchronous
- inst_data  output  N  head-of-FIFO instruction
- inst_valid  output  1  FIFO non-empty
- inst_ready  input  1  consumer accepts head when inst_valid && inst_ready
- fifo_count  output  $clog2(DEPTH+1)  frames currently queued
- busy  output  1  frame reception in progress (FSM in SHIFT)
- frame_len_err  output  1  sticky: frame ended with bit count != N
- overflow  output  1  sticky: complete frame dropped because FIFO full
- clear_err  input  1  one-cycle pulse clears both sticky flags

Behaviour:
- Reset: one clock is used; reset is synchronous and active-high. Reset clears FSM to ARM, the shift register, the bit counter, the FIFO (fifo_count=0, inst_valid=0), busy=0, frame_len_err=0 and overflow=0. inst_data is don't-care while inst_valid=0. Synchronizer flops reset to cs=1, sclk=0, mosi=0.
- Input sync: each of RPiclk, MOSI and cs1 passes through SYNC flops. Edge detection uses one additional history flop per signal.
- sclk_rise: synced RPiclk 0->1. cs_fall / cs_rise: edges of synced cs1.
- Requirement: RPiclk period >= 4 clk periods and high/low phases >= 2 clk each. Behaviour outside this limit is unspecified.
- FSM:
  - ARM: waits for synced cs1=1, then goes to IDLE. This discards any frame that was in progress at reset.
  - IDLE: on cs_fall, clear the bit counter and go to SHIFT.
  - SHIFT: on sclk_rise, shift = {shift[N-2:0], mosi_sync} and bitcnt++ (saturating at N+1). On cs_rise, evaluate the frame and return to IDLE. busy=1 only in SHIFT.
- Frame evaluation, in the cs_rise cycle:
  - bitcnt==N and FIFO not full (or a pop occurs in the same cycle): push shift into the FIFO.
  - bitcnt==N and FIFO full with no pop: drop the frame and set overflow.
  - bitcnt!=N (including 0 bits and more than N bits): drop the frame and set frame_len_err. No push occurs.
- If sclk_rise and cs_rise land in the same clk cycle, the shift is applied first and the frame is evaluated with the updated count.
- FIFO:
  - Registered storage with circular read/write pointers of width $clog2(DEPTH) that wrap at DEPTH.
  - Pop = inst_valid && inst_ready.
  - Simultaneous push and pop: both occur and fifo_count is unchanged, including when full and when count==1.
  - inst_valid and fifo_count update on the clk edge after a push or pop. Push-to-inst_valid latency is 1 clk after the cs_rise cycle.
  - inst_data is stable while inst_valid=1 and no pop occurs.
- Sticky flags: set has priority over clear_err in the same cycle. Flags are only cleared by clear_err or reset.
- Reset mid-frame: the partial frame is lost and the FSM goes to ARM. No frame is pushed until cs1 has been seen high and then low again.

Test Plan:
- Send one 80-bit frame 0xA5A5_0000_1234_5678_9ABC, cs1 high -> 1 clk after the synced cs_rise: inst_valid=1, inst_data matches, fifo_count=1. With inst_ready=1: fifo_count=0 and inst_valid=0 next cycle.
- Send 5 valid frames with inst_ready=0 (DEPTH=4) -> fifo_count=4, overflow=1. Drain with inst_ready=1: frames 1-4 come out in order and frame 5 never appears.
- Send a 79-bit frame, then an 81-bit frame, then a 0-bit frame (cs1 toggled only) -> no push for any of them, frame_len_err=1. Pulse clear_err: frame_len_err=0.
- FIFO full, inst_ready=1 held, 5th frame's cs_rise coincides with a pop -> frame accepted, fifo_count stays 4, overflow stays 0.
- Assert reset after 40 bits of a frame while cs1 remains low, release reset, finish the remaining 40 bits, then send a full frame -> only the second frame is queued (fifo_count=1), frame_len_err=0.
- Push and pop DEPTH*3 frames in alternation -> pointers wrap correctly and all 12 frames come out in order with matching data.
